mock_uart_tx: RTL
=================

MOCK_UART_TX -- requirements
Module: mock_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the number of clk cycles per UART bit; legal range is 2 or more.
REQ-002 Parameter FIFO_DEPTH, default 4, is the byte FIFO depth; it is a power of two, 2 or more.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  8  byte to transmit.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle; equals !fifo_full && !rst.
REQ-008 tx_sig  output  1  registered UART serial line (8N1, idle high); drives the SoC uart_rx in sim_top.
REQ-009 busy  output  1  high when state != IDLE or the FIFO is non-empty.
REQ-010 tx_done  output  1  one-cycle pulse marking the end of each stop bit.

Function
REQ-011 A byte SHALL be accepted and pushed into the FIFO on each rising edge where in_valid && in_ready; in_data is ignored otherwise.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 IDLE with FIFO non-empty SHALL pop the head byte into an 8-bit shift register and enter START on the next edge.
- A byte accepted at edge N drives tx_sig low from edge N+1.
REQ-014 The baud counter SHALL count 0 to CLKS_PER_BIT-1 and wrap; each state holds for exactly CLKS_PER_BIT cycles per bit.
REQ-015 START SHALL drive tx_sig=0.
REQ-016 DATA SHALL send 8 bits LSB first, using a 3-bit index 0..7; after bit 7 completes, the FSM enters STOP.
REQ-017 STOP SHALL drive tx_sig=1; on its final cycle tx_done=1.
REQ-018 At the end of STOP, the FSM SHALL go to START if the FIFO is non-empty (popping in the same cycle, no idle gap), else to IDLE.
REQ-019 One frame SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
REQ-020 FIFO full rules:
- in_ready=0, so no push occurs.
- A pop while full frees one slot, visible as in_ready=1 on the following cycle.
REQ-021 A simultaneous push and pop on a non-empty FIFO SHALL leave its count unchanged and preserve order.
REQ-022 FIFO pointers SHALL be log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, and use a count field one bit wider.
REQ-023 Push on empty and pop in the same cycle SHALL NOT occur; a pop requires a stored entry (no fall-through).

Reset
REQ-024 While rst=1 at an edge, the block SHALL set:
- tx_sig=1, tx_done=0, busy=0, state=IDLE;
- baud counter=0, bit index=0, FIFO count and pointers=0;
- in_ready=0 during reset and 1 on the first cycle after it.
REQ-025 Reset mid-frame SHALL abort the frame: tx_sig is high from the next edge, FIFO contents are discarded, and no tx_done pulse is generated.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (uart_tx_state_t), UART_DATA_BITS=8 and the default CLKS_PER_BIT.
REQ-027 The FIFO SHALL be a separate sub-module, uart_tx_fifo, parameterised by depth and width, exposing push, pop, full, empty and count.
REQ-028 The FSM, baud counter and shift register SHALL reside in mock_uart_tx; sim_top instantiates mock_uart_tx driving uart_rx in place of the constant tie-off.

Verification
REQ-029 CLKS_PER_BIT=4; push 0x55 -> tx_sig = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done pulses 40 cycles after tx_sig first falls; busy=0 afterwards.
REQ-030 Push 0xA3 then 0x0F on consecutive cycles -> 20 contiguous bits (0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1) with no idle cycle between frames; two tx_done pulses 40 cycles apart.
REQ-031 FIFO_DEPTH=4; in_valid=1 for 6 consecutive cycles (bytes 0x01..0x06):
- the first 5 bytes are accepted and in_ready falls after the 5th;
- 0x06 is accepted only after the first frame ends;
- output order is 0x01..0x06.
REQ-032 Assert rst for 1 cycle during DATA bit 3 of 0x00 -> tx_sig=1 next cycle, no tx_done, busy=0, and the FIFO is empty.
REQ-033 Loopback: mock_uart_tx feeds mock_uart_rx at the same CLKS_PER_BIT; send 0x48,0x69,0x0A -> the receiver reports 0x48,0x69,0x0A in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the mock UART transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO: power-of-two depth, registered storage, no fall-through.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CountFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Overflow and underflow are blocked here so callers cannot corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mock_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames go back-to-back while data is queued.
module mock_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      tx_sig,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BitLast = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [BaudW-1:0]          baud_q, baud_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      bit_end;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state_q != StIdle) || (fifo_count != '0);
  assign tx_sig    = tx_q;
  assign bit_end   = (baud_q == BaudLast);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state: bit timing, shift register and FIFO pop decisions.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_done   = 1'b0;
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          tx_done = 1'b1;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the upcoming cycle, registered so tx_sig is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = shift_d[0];
    end
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule
